adc_scan_sequencer: RTL

Periodic scan scheduler for the LTC2308 SPI conversion engine. On a programmable period tick it walks the enabled channel set in ascending order and issues one conversion per channel plus one trailing flush conversion. The flush is needed because the converter returns the result of the *previous* channel selection. Each returned sample is tagged with its true channel and presented as a one-cycle result strobe for a result bank or FIFO writer.

---
 rtl/adc_seq_pkg.sv | 26 ++
 rtl/adc_scan_sequencer_if.sv | 31 +++
 rtl/adc_seq_next_ch.sv | 33 +++
 rtl/adc_scan_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// -----------------------------------------------------------------------------
// adc_seq_pkg
// Shared constants and types for the ADC scan sequencer.
//   NCH       number of converter channels
//   CH_W      channel index width
//   SAMPLE_W  converter sample width
//   seq_state_e  scan FSM states
// -----------------------------------------------------------------------------
package adc_seq_pkg;

  localparam int NCH      = 8;
  localparam int CH_W     = $clog2(NCH);
  localparam int SAMPLE_W = 12;

  typedef logic [NCH-1:0]      ch_mask_t;
  typedef logic [CH_W-1:0]     ch_t;
  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/adc_scan_sequencer_if.sv
// -----------------------------------------------------------------------------
// adc_scan_sequencer_if
// Converter handshake plus result strobe bus of the scan sequencer.
//   conv_start/conv_ch     request to the conversion engine
//   conv_done/conv_data    completion level and sample from the engine
//   res_valid/res_ch/res_data/scan_done  tagged result stream
// master: the sequencer.  slave: converter + result consumer side.
// -----------------------------------------------------------------------------
interface adc_scan_sequencer_if;
  import adc_seq_pkg::*;

  logic    conv_start;
  ch_t     conv_ch;
  logic    conv_done;
  sample_t conv_data;
  logic    res_valid;
  ch_t     res_ch;
  sample_t res_data;
  logic    scan_done;

  modport master (
    output conv_start, conv_ch, res_valid, res_ch, res_data, scan_done,
    input  conv_done, conv_data
  );

  modport slave (
    input  conv_start, conv_ch, res_valid, res_ch, res_data, scan_done,
    output conv_done, conv_data
  );

endinterface

// File: rtl/adc_seq_next_ch.sv
// -----------------------------------------------------------------------------
// adc_seq_next_ch
// Combinational priority search: lowest set bit of mask_i strictly above
// idx_i. idx_i is signed so that -1 yields the lowest set bit overall.
//   mask_i   channel mask
//   idx_i    search starts above this index (-1 .. NCH-1)
//   found_o  a qualifying bit exists
//   next_o   index of that bit (0 when none)
// -----------------------------------------------------------------------------
module adc_seq_next_ch
  import adc_seq_pkg::*;
(
  input  ch_mask_t           mask_i,
  input  logic signed [CH_W:0] idx_i,
  output logic               found_o,
  output ch_t                next_o
);

  // NOTE: every output gets a default before the loop so no path leaves
  // it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    found_o = 1'b0;
    next_o  = '0;
    // Descending scan: the last hit written is the lowest qualifying bit.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_i[i] && (i > int'(idx_i))) begin
        found_o = 1'b1;
        next_o  = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// -----------------------------------------------------------------------------
// adc_scan_sequencer
// Periodic scan scheduler for an LTC2308-style converter that returns the
// result of the *previous* channel selection. Each scan converts every
// enabled channel in ascending order plus one trailing flush conversion;
// the first (priming) result is discarded and each later result is tagged
// with the channel that was selected one conversion earlier.
//
// Ports
//   clock, reset_n   system clock, async active-low reset
//   cfg_enable_i     scanning enabled (period timer held at 0 when low)
//   cfg_ch_mask_i    channel enable mask, latched at scan start
//   cfg_period_i     clocks between scan ticks (0 behaves as 1)
//   clear_err_i      clears sticky error flags (a same-cycle set wins)
//   busy_o           FSM not idle
//   err_overrun_o    sticky: tick arrived while busy
//   err_timeout_o    sticky: converter did not finish within TIMEOUT clocks
//   bus              converter handshake + result stream (master side)
// -----------------------------------------------------------------------------
module adc_scan_sequencer
  import adc_seq_pkg::*;
#(
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT  = 1023
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                cfg_enable_i,
  input  ch_mask_t            cfg_ch_mask_i,
  input  logic [PERIOD_W-1:0] cfg_period_i,
  input  logic                clear_err_i,
  output logic                busy_o,
  output logic                err_overrun_o,
  output logic                err_timeout_o,
  adc_scan_sequencer_if.master bus
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // Period timer
  // ---------------------------------------------------------------------------
  logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
  logic [PERIOD_W-1:0] period_max;
  logic                tick;

  assign period_max = (cfg_period_i == '0) ? PERIOD_W'(1) : cfg_period_i;
  // >= rather than == so a period shortened below the running count
  // wraps at once instead of running through the whole counter range.
  assign tick = cfg_enable_i && (period_cnt_q >= period_max - PERIOD_W'(1));

  always_comb begin
    period_cnt_d = period_cnt_q + PERIOD_W'(1);
    if (!cfg_enable_i || tick) period_cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) period_cnt_q <= '0;
    else          period_cnt_q <= period_cnt_d;
  end

  // ---------------------------------------------------------------------------
  // Scan FSM state
  // ---------------------------------------------------------------------------
  seq_state_e      state_q;
  ch_mask_t        scan_mask_q;
  ch_t             ptr_q;        // channel of the current non-flush conversion
  ch_t             last_ch_q;    // channel selected one conversion earlier
  logic            first_q;      // in-flight conversion is the priming one
  logic            flush_q;      // in-flight / next conversion is the flush
  logic [TO_W-1:0] wait_cnt_q;
  logic            conv_done_q;

  logic    conv_start_q, res_valid_q, scan_done_q;
  ch_t     conv_ch_q, res_ch_q;
  sample_t res_data_q;
  logic    err_overrun_q, err_timeout_q;

  logic    done_rise;
  logic    low_found, adv_found;
  ch_t     low_ch, adv_ch;
  ch_mask_t low_mask;

  assign done_rise = bus.conv_done && !conv_done_q;

  // In IDLE the lowest bit is taken from the live config (to start a scan);
  // otherwise from the latched mask (flush channel).
  assign low_mask = (state_q == S_IDLE) ? cfg_ch_mask_i : scan_mask_q;

  adc_seq_next_ch u_lowest (
    .mask_i  (low_mask),
    .idx_i   ({(CH_W + 1){1'b1}}),
    .found_o (low_found),
    .next_o  (low_ch)
  );

  adc_seq_next_ch u_advance (
    .mask_i  (scan_mask_q),
    .idx_i   ({1'b0, ptr_q}),
    .found_o (adv_found),
    .next_o  (adv_ch)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      scan_mask_q   <= '0;
      ptr_q         <= '0;
      last_ch_q     <= '0;
      first_q       <= 1'b0;
      flush_q       <= 1'b0;
      wait_cnt_q    <= '0;
      conv_done_q   <= 1'b0;
      conv_start_q  <= 1'b0;
      conv_ch_q     <= '0;
      res_valid_q   <= 1'b0;
      res_ch_q      <= '0;
      res_data_q    <= '0;
      scan_done_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      conv_start_q <= 1'b0;
      res_valid_q  <= 1'b0;
      scan_done_q  <= 1'b0;
      conv_done_q  <= bus.conv_done;

      // Clear first; any set later in this block overrides it.
      if (clear_err_i) begin
        err_overrun_q <= 1'b0;
        err_timeout_q <= 1'b0;
      end
      if (tick && (state_q != S_IDLE)) err_overrun_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          // The first conversion is launched straight from IDLE so it
          // appears on the cycle after the tick.
          if (tick && low_found) begin
            scan_mask_q  <= cfg_ch_mask_i;
            ptr_q        <= low_ch;
            first_q      <= 1'b1;
            flush_q      <= 1'b0;
            last_ch_q    <= conv_ch_q;
            conv_ch_q    <= low_ch;
            conv_start_q <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (conv_start_q) begin
            // Launched from IDLE; the start cycle already counts as waiting.
            wait_cnt_q <= TO_W'(1);
            state_q    <= S_WAIT;
          end else if (!cfg_enable_i) begin
            state_q <= S_IDLE;
          end else begin
            last_ch_q    <= conv_ch_q;
            conv_ch_q    <= flush_q ? low_ch : ptr_q;
            conv_start_q <= 1'b1;
            wait_cnt_q   <= '0;
            state_q      <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (done_rise) begin
            if (!cfg_enable_i) begin
              // Scan abandoned: the in-flight result is dropped.
              state_q <= S_IDLE;
            end else begin
              if (!first_q) begin
                res_valid_q <= 1'b1;
                res_ch_q    <= last_ch_q;
                res_data_q  <= bus.conv_data;
              end
              if (flush_q) begin
                scan_done_q <= 1'b1;
                state_q     <= S_DONE;
              end else begin
                first_q <= 1'b0;
                if (adv_found) ptr_q   <= adv_ch;
                else           flush_q <= 1'b1;
                state_q <= S_ISSUE;
              end
            end
          end else if (wait_cnt_q >= TO_LAST) begin
            err_timeout_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + TO_W'(1);
          end
        end

        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.conv_start = conv_start_q;
  assign bus.conv_ch    = conv_ch_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_ch     = res_ch_q;
  assign bus.res_data   = res_data_q;
  assign bus.scan_done  = scan_done_q;
  assign busy_o         = (state_q != S_IDLE);
  assign err_overrun_o  = err_overrun_q;
  assign err_timeout_o  = err_timeout_q;

endmodule
